// File: rtl/sweep_pkg.sv
// Shared widths, FSM encoding and a small helper for the sweep learner.
// Pure declarations: no latency or flow control of its own.
package sweep_pkg;

    localparam int ADC_W  = 10;
    localparam int PP_W   = 11;
    localparam int FREQ_W = 16;

    localparam logic signed [ADC_W-1:0] ADC_MIN = {1'b1, {(ADC_W-1){1'b0}}};
    localparam logic signed [ADC_W-1:0] ADC_MAX = {1'b0, {(ADC_W-1){1'b1}}};

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_SETTLE  = 3'd1;
    localparam state_t S_MEASURE = 3'd2;
    localparam state_t S_STORE   = 3'd3;
    localparam state_t S_STEP    = 3'd4;
    localparam state_t S_EXIT    = 3'd5;
    localparam state_t S_DONE    = 3'd6;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/peak_detect.sv
// Signed min/max tracker giving the peak-to-peak span of the samples seen since clear; pp is 0 if none.
// Latency: one cycle from a sample to pp; no backpressure, every valid sample is absorbed.
module peak_detect
    import sweep_pkg::*;
(
    input  logic                    clk_50m,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    valid,
    input  logic signed [ADC_W-1:0] data,
    output logic [PP_W-1:0]         pp
);

    logic signed [ADC_W-1:0] max_v;
    logic signed [ADC_W-1:0] min_v;
    logic                    seen;
    logic [PP_W-1:0]         diff;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            max_v <= ADC_MIN;
            min_v <= ADC_MAX;
            seen  <= 1'b0;
        end else if (clear) begin
            max_v <= ADC_MIN;
            min_v <= ADC_MAX;
            seen  <= 1'b0;
        end else if (valid) begin
            if (data > max_v) max_v <= data;
            if (data < min_v) min_v <= data;
            seen <= 1'b1;
        end
    end

    // One extra bit so a full-scale span (1023) cannot wrap.
    assign diff = {max_v[ADC_W-1], max_v} - {min_v[ADC_W-1], min_v};
    assign pp   = seen ? diff : '0;

endmodule

// File: rtl/sweep_learner.sv
// Learn-mode sequencer: steps the generator N_STEPS times, records {freq_in, pp_amp} per step.
// Latency: first record 1+SETTLE_CYC+MEAS_CYC cycles after start; no backpressure, abort is the only early exit.
module sweep_learner
    import sweep_pkg::*;
#(
    parameter int N_STEPS    = 100,
    parameter int SETTLE_CYC = 500000,
    parameter int MEAS_CYC   = 1000000,
    parameter int PULSE_CYC  = 4,
    parameter int EXIT_CYC   = 4,
    parameter int F_START    = 10,
    parameter int F_STEP     = 2,
    localparam int AW        = (N_STEPS > 1) ? $clog2(N_STEPS) : 1
) (
    input  logic                    clk_50m,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    adc_valid,
    input  logic signed [ADC_W-1:0] adc_data,
    input  logic [FREQ_W-1:0]       freq_in,
    output logic                    learn_en,
    output logic                    next_freq,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    wr_en,
    output logic [AW-1:0]           wr_addr,
    output logic [FREQ_W+PP_W-1:0]  wr_data
);

    localparam int CNT_MAX = max_int(max_int(SETTLE_CYC, MEAS_CYC), max_int(2 * PULSE_CYC, EXIT_CYC));
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [AW-1:0] LAST_STEP = AW'(N_STEPS - 1);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [AW-1:0]     step;
    logic              pk_clear;
    logic              pk_valid;
    logic [PP_W-1:0]   pp_amp;
    logic [FREQ_W-1:0] exp_freq;
    logic              abortable;

    assign pk_clear  = (state == S_SETTLE) && (cnt == CW'(SETTLE_CYC - 1));
    assign pk_valid  = (state == S_MEASURE) && adc_valid;
    assign exp_freq  = FREQ_W'(F_START) + FREQ_W'(F_STEP) * FREQ_W'(step);
    assign abortable = state inside {S_SETTLE, S_MEASURE, S_STORE, S_STEP};

    peak_detect u_peak (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .clear   (pk_clear),
        .valid   (pk_valid),
        .data    (adc_data),
        .pp      (pp_amp)
    );

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            step      <= '0;
            learn_en  <= 1'b0;
            next_freq <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            // Abort pre-empts everything, including the STORE write of the current step.
            if (abort && abortable) begin
                state     <= S_EXIT;
                cnt       <= '0;
                learn_en  <= 1'b0;
                next_freq <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state    <= S_SETTLE;
                            learn_en <= 1'b1;
                            busy     <= 1'b1;
                            err      <= 1'b0;
                            step     <= '0;
                            cnt      <= '0;
                        end
                    end
                    S_SETTLE: begin
                        if (cnt == CW'(SETTLE_CYC - 1)) begin
                            state <= S_MEASURE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_MEASURE: begin
                        if (cnt == CW'(MEAS_CYC - 1)) begin
                            state <= S_STORE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_STORE: begin
                        wr_en   <= 1'b1;
                        wr_addr <= step;
                        wr_data <= {freq_in, pp_amp};
                        if (freq_in != exp_freq) err <= 1'b1;
                        cnt <= '0;
                        if (step == LAST_STEP) begin
                            state    <= S_EXIT;
                            learn_en <= 1'b0;
                        end else begin
                            state     <= S_STEP;
                            next_freq <= 1'b1;
                        end
                    end
                    S_STEP: begin
                        // High for cnt 0..PULSE_CYC-1, then low for the remaining PULSE_CYC cycles.
                        if (cnt == CW'(2 * PULSE_CYC - 1)) begin
                            state     <= S_SETTLE;
                            cnt       <= '0;
                            step      <= step + 1'b1;
                            next_freq <= 1'b0;
                        end else begin
                            cnt       <= cnt + 1'b1;
                            next_freq <= (cnt < CW'(PULSE_CYC - 1));
                        end
                    end
                    S_EXIT: begin
                        if (cnt == CW'(EXIT_CYC - 1)) begin
                            state <= S_DONE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_DONE: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
